// File: rtl/div_iter.sv
// ---------------------------------------------------------------------------
// div_iter -- multi-cycle integer divider for DIV / DIVU.
//
// Works alongside the single-cycle EX-stage ALU. EX presents operands with a
// one-cycle start pulse. The pipeline stays stalled while busy_o is high.
// The divider produces {remainder, quotient} for the HI/LO write path and
// raises ready_o for one cycle when the result is valid.
// It uses radix-2 restoring division and retires one quotient bit per cycle.
//
// Ports
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous reset, active-low; overrides every other input
//   start_i    in   request; sampled only in IDLE
//   signed_i   in   1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   opdata1_i  in   dividend; sampled with start_i
//   opdata2_i  in   divisor;  sampled with start_i
//   annul_i    in   cancel the in-flight op (acted on in BYZERO and ON only)
//   result_o   out  {remainder, quotient}; loaded on entry to END, then held
//   ready_o    out  one-cycle pulse while in END
//   busy_o     out  high whenever the FSM is not IDLE (stall request)
// ---------------------------------------------------------------------------
module div_iter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;

  // Datapath registers.
  logic [DATA_W-1:0]    divisor;   // |opdata2|
  logic [DATA_W-1:0]    dq;        // dividend bits shift out of the top; quotient bits shift in at the bottom
  logic [DATA_W-1:0]    p;         // partial remainder; always < divisor, so DATA_W bits suffice
  logic                 neg_quo;
  logic                 neg_rem;

  // Two's-complement magnitude in DATA_W bits. The most negative value maps
  // to itself, and that is its correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                  input logic              is_signed);
    return (is_signed && v[DATA_W-1]) ? -v : v;
  endfunction

  // One restoring step. The trial value {P, next dividend bit} is DATA_W+1 bits.
  // When it is >= divisor the true difference is < divisor, so keeping only the
  // low DATA_W bits of the subtraction is exact.
  logic [DATA_W:0]      trial;
  logic                 q_bit;
  logic [DATA_W-1:0]    diff;
  logic [DATA_W-1:0]    p_next;
  logic [DATA_W-1:0]    dq_next;
  logic [DATA_W-1:0]    quo_final;
  logic [DATA_W-1:0]    rem_final;

  // NOTE: every always_comb output gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    trial     = {p, dq[DATA_W-1]};
    q_bit     = 1'b0;
    diff      = '0;
    p_next    = trial[DATA_W-1:0];
    dq_next   = {dq[DATA_W-2:0], 1'b0};
    quo_final = '0;
    rem_final = '0;

    q_bit   = (trial >= {1'b0, divisor});
    diff    = trial[DATA_W-1:0] - divisor;
    if (q_bit) p_next = diff;
    dq_next = {dq[DATA_W-2:0], q_bit};

    // Sign fix-up is applied to the values of the final step as it retires.
    quo_final = neg_quo ? -dq_next : dq_next;
    rem_final = neg_rem ? -p_next  : p_next;
  end

  // Control FSM and registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      ready_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            if (opdata2_i == '0) begin
              state <= BYZERO;
            end else begin
              state <= ON;
              cnt   <= '0;
            end
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= IDLE;
          end else begin
            state    <= END;
            ready_o  <= 1'b1;
            result_o <= '0;
          end
        end
        ON: begin
          if (annul_i) begin
            state <= IDLE;
          end else if (cnt == LAST_STEP) begin
            state    <= END;
            ready_o  <= 1'b1;
            result_o <= {rem_final, quo_final};
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        END:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the datapath has no reset. Each of these registers is loaded on
  // acceptance before anything reads it, so resetting them would only add
  // reset fan-out.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_i) begin
      divisor <= magnitude(opdata2_i, signed_i);
      dq      <= magnitude(opdata1_i, signed_i);
      p       <= '0;
      neg_quo <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
      neg_rem <= signed_i & opdata1_i[DATA_W-1];
    end else if (state == ON) begin
      p  <= p_next;
      dq <= dq_next;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_div_iter.sv
// ---------------------------------------------------------------------------
// tb_div_iter -- directed bench for div_iter with hand-computed expectations.
// Inputs change on the falling edge and outputs are sampled there too, away
// from the rising edge. "Cycle N" means the N-th clock after the cycle in
// which start_i was presented (cycle 0).
// ---------------------------------------------------------------------------
module tb_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int n_checks = 0;
  int n_errors = 0;

  div_iter #(.DATA_W(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request at the next falling edge (cycle 0), then watch up to
  // 40 cycles for ready_o. lat = -1 when the bound expires. Unless hold is set,
  // start drops after cycle 0 and the operand buses are scrambled, so the
  // result must come from the operands latched at acceptance.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic hold, output int lat, output int busy_n,
                        output logic [63:0] res);
    lat    = -1;
    busy_n = 0;
    res    = 'x;
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!hold) begin
        start_i = 1'b0; opdata1_i = ~a; opdata2_i = 32'h0; signed_i = ~sgn;
      end
      if (busy_o) busy_n++;
      if (ready_o) begin
        lat = c; res = result_o; start_i = 1'b0;
        break;
      end
    end
    start_i = 1'b0;
  endtask

  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_res,
                        input int exp_lat);
    int lat, busy_n;
    logic [63:0] res;
    run_op(sgn, a, b, 1'b0, lat, busy_n, res);
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " result"}, res, exp_res);
  endtask

  // Present a request and stop at the falling edge of cycle 1.
  task automatic start_only(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start_i = 1'b1; signed_i = sgn; opdata1_i = a; opdata2_i = b;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  initial begin
    int lat, busy_n, ready_seen;
    logic [63:0] res;

    rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset result_o", result_o, 64'h0);
    check("reset ready_o", 64'(ready_o), 64'h0);
    check("reset busy_o", 64'(busy_o), 64'h0);
    rst = 1'b1;

    // DIVU 100/7: latency, busy window, single-cycle pulse.
    run_op(1'b0, 32'd100, 32'd7, 1'b0, lat, busy_n, res);
    check("divu 100/7 latency", 64'(lat), 64'd33);
    check("divu 100/7 busy cycles", 64'(busy_n), 64'd33);
    check("divu 100/7 result", res, {32'd2, 32'd14});
    @(negedge clk);
    check("divu 100/7 ready pulse width", 64'(ready_o), 64'h0);
    check("divu 100/7 idle busy", 64'(busy_o), 64'h0);
    check("divu 100/7 result held", result_o, {32'd2, 32'd14});

    // Signed cases.
    do_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    do_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
    do_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14}, 33);
    do_div("divu ffffffff/16", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'h0000_000F, 32'h0FFF_FFFF}, 33);

    // Divide by zero.
    run_op(1'b0, 32'h1234, 32'h0, 1'b0, lat, busy_n, res);
    check("div0 latency", 64'(lat), 64'd2);
    check("div0 result", res, 64'h0);
    check("div0 busy cycles", 64'(busy_n), 64'd2);
    @(negedge clk);
    check("div0 ready pulse width", 64'(ready_o), 64'h0);

    // Most-negative dividend by -1, signed and unsigned.
    do_div("div 80000000/ffffffff", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
    // Back-to-back: this start lands in the IDLE cycle right after the previous END.
    do_div("divu 80000000/ffffffff b2b", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 33);

    // start_i held high through ON changes nothing.
    run_op(1'b0, 32'd1000, 32'd3, 1'b1, lat, busy_n, res);
    check("held start latency", 64'(lat), 64'd33);
    check("held start result", res, {32'd1, 32'd333});

    // Divisor larger than dividend; establishes the value annul must preserve.
    do_div("divu 5/9", 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 33);

    // annul_i in cycle 10: IDLE in cycle 11, no pulse, result held.
    start_only(1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul busy cleared", 64'(busy_o), 64'h0);
    check("annul result held", result_o, {32'd5, 32'd0});
    ready_seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o) ready_seen++;
    end
    check("annul no ready pulse", 64'(ready_seen), 64'h0);
    do_div("after annul divu 1000/3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);

    // annul_i while in BYZERO: back to IDLE, no pulse.
    start_only(1'b0, 32'd5, 32'd0);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    check("byzero annul ready", 64'(ready_o), 64'h0);
    check("byzero annul busy", 64'(busy_o), 64'h0);
    check("byzero annul result held", result_o, {32'd1, 32'd333});

    // Reset in cycle 20 of an op: all outputs 0 next cycle.
    start_only(1'b1, 32'hFFFF_FFF9, 32'd2);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mid-op reset busy", 64'(busy_o), 64'h0);
    check("mid-op reset ready", 64'(ready_o), 64'h0);
    check("mid-op reset result", result_o, 64'h0);
    rst = 1'b1;
    do_div("after reset div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
